// File: rtl/sound_pkg.sv
// Shared constants and state encoding for the sound input subsystem.
package sound_pkg;

    localparam int unsigned SND_WIN_LOG2_DEF    = 9;
    localparam int unsigned SND_ACT_WINDOWS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN
    } snd_state_t;

endpackage

// File: rtl/sound_demod_if.sv
// Control inputs and recovered-sample outputs of sound_demod.
// master: the demodulator; slave: the consumer that enables it and reads samples.
interface sound_demod_if;

    logic       enable;
    logic       bit_in;
    logic [7:0] sample;
    logic       sample_stb;
    logic       sample_chg;
    logic       active;

    modport master (
        input  enable,
        input  bit_in,
        output sample,
        output sample_stb,
        output sample_chg,
        output active
    );

    modport slave (
        output enable,
        output bit_in,
        input  sample,
        input  sample_stb,
        input  sample_chg,
        input  active
    );

endinterface

// File: rtl/sound_in_cond.sv
// Input conditioning for the PWM bitstream: 2-FF synchronizer, optional 3-tap
// majority filter (SOUND_DEMOD_GLITCH_FILTER_EN) and edge detect on the result.
module sound_in_cond (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    output logic bit_s,
    output logic edge_det
);

    logic sync1;
    logic sync2;
    logic bit_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bit_in;
            sync2 <= sync1;
        end
    end

`ifdef SOUND_DEMOD_GLITCH_FILTER_EN
    logic tap1;
    logic tap2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap1 <= 1'b0;
            tap2 <= 1'b0;
        end else begin
            tap1 <= sync2;
            tap2 <= tap1;
        end
    end

    // Majority of three consecutive samples; centred on tap1, hence one extra clock.
    assign bit_s = (sync2 & tap1) | (sync2 & tap2) | (tap1 & tap2);
`else
    assign bit_s = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_s_q <= 1'b0;
        end else begin
            bit_s_q <= bit_s;
        end
    end

    assign edge_det = bit_s ^ bit_s_q;

endmodule

// File: rtl/sound_demod.sv
// Recovers 8-bit samples from a 512-clock triangle-PWM bitstream by counting high
// clocks per window. Build option: SOUND_DEMOD_GLITCH_FILTER_EN (see sound_in_cond).
module sound_demod
    import sound_pkg::*;
#(
    parameter int unsigned WIN_LOG2    = SND_WIN_LOG2_DEF,
    parameter int unsigned ACT_WINDOWS = SND_ACT_WINDOWS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sound_demod_if.master bus
);

    localparam int unsigned SHIFT = WIN_LOG2 - 8;
    localparam int unsigned ICW   = $clog2(ACT_WINDOWS + 1);
    localparam logic [ICW-1:0] ACT_MAX = ICW'(ACT_WINDOWS);

    snd_state_t          state;
    snd_state_t          state_nxt;
    logic [WIN_LOG2-1:0] wctr;
    logic [WIN_LOG2:0]   ones;
    logic [WIN_LOG2:0]   full;
    logic [WIN_LOG2:0]   scaled;
    logic [7:0]          result;
    logic [7:0]          sample_q;
    logic                stb_q;
    logic                chg_q;
    logic                edge_seen;
    logic [ICW-1:0]      idle_cnt;
    logic                bit_s;
    logic                edge_det;
    logic                counting;
    logic                wend;

    sound_in_cond u_cond (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bus.bit_in),
        .bit_s    (bit_s),
        .edge_det (edge_det)
    );

    assign counting = bus.enable && (state != S_IDLE);
    assign wend     = counting && (wctr == '1);

    // ones holds the window minus the current clock; full folds the current bit in,
    // so ones can simply clear at the boundary without losing a cycle.
    assign full   = ones + {{WIN_LOG2{1'b0}}, bit_s};
    assign scaled = full >> SHIFT;
    assign result = (|scaled[WIN_LOG2:8]) ? 8'hFF : scaled[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_FILL;
                S_FILL:  if (wend) state_nxt = S_RUN;
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wctr      <= '0;
            ones      <= '0;
            edge_seen <= 1'b0;
            idle_cnt  <= ACT_MAX;
            sample_q  <= 8'h00;
            stb_q     <= 1'b0;
            chg_q     <= 1'b0;
        end else if (!counting) begin
            wctr      <= '0;
            ones      <= '0;
            edge_seen <= 1'b0;
            idle_cnt  <= ACT_MAX;
            stb_q     <= 1'b0;
            chg_q     <= 1'b0;
        end else begin
            wctr  <= wctr + 1'b1;
            stb_q <= 1'b0;
            chg_q <= 1'b0;
            if (wend) begin
                ones      <= '0;
                edge_seen <= 1'b0;
                if (edge_seen || edge_det) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != ACT_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (state == S_RUN) begin
                    sample_q <= result;
                    chg_q    <= (result != sample_q);
                    stb_q    <= 1'b1;
                end
            end else begin
                ones      <= full;
                edge_seen <= edge_seen | edge_det;
            end
        end
    end

    assign bus.sample     = sample_q;
    assign bus.sample_stb = stb_q;
    assign bus.sample_chg = chg_q;
    assign bus.active     = (idle_cnt < ACT_MAX);

endmodule
